// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queues {op,len} JK commands and replays each op on registered j,k for len+1 cycles.
// Latency: a command pushed into an empty FIFO while idle drives j,k from the next edge; queued commands chain with no gap.
// Backpressure: cmd_ready drops only while the FIFO holds DEPTH entries; it never looks at cmd_valid or a same-cycle pop.
//
// Ports (jk_cmd_fifo):
//   clk, reset            rising-edge clock, synchronous active-high reset (empties the FIFO)
//   push, push_dat        write push_dat at the tail; caller only pushes when not full
//   pop                   drop the head entry; caller only pops when not empty
//   head_dat, level       current head entry and number of stored entries
//
// Ports (jk_cmd_seq):
//   clk, reset            rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; {cmd_op, cmd_len} captured when both are 1
//   cmd_op, cmd_len       {j,k} code (00 hold, 01 clear, 10 set, 11 toggle) and repeat count
//   j, k                  registered drive to the downstream JK flip-flop
//   busy                  a command is being issued
//   q_exp                 predicted q of the downstream flip-flop
//   fifo_level            queued entries, not counting the one in issue

module jk_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 6
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [LW-1:0] LVL_ONE = LW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Storage needs no reset: level/pointers decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !reset) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap modulo DEPTH by plain overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_ONE;
            2'b01:   level <= level - LVL_ONE;
            default: level <= level;
         endcase
      end
   end

   assign head_dat = mem[rd_ptr];

endmodule

module jk_cmd_seq #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [CNT_W-1:0]         cmd_len,
   output logic                     j,
   output logic                     k,
   output logic                     busy,
   output logic                     q_exp,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int LW = $clog2(DEPTH) + 1;
   localparam int EW = CNT_W + 2;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [0:0]       state_q;
   logic [CNT_W-1:0] rem_q;
   logic [LW-1:0]    level;
   logic [EW-1:0]    head;
   logic             push;
   logic             pop;
   logic             fifo_empty;
   logic             issue_done;

   // Ready is purely a function of stored level so it can't form a loop with
   // upstream valid, and a pop in the same cycle does not open an extra slot.
   assign cmd_ready  = (level < FULL_LVL);
   assign push       = cmd_valid && cmd_ready && !reset;
   assign fifo_empty = (level == '0);

   // The current command finishes this edge when idle or on its last cycle;
   // popping then gives gap-free chaining of queued commands.
   assign issue_done = (state_q == IDLE) || (rem_q == '0);
   assign pop        = issue_done && !fifo_empty && !reset;

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat ({cmd_op, cmd_len}),
      .pop      (pop),
      .head_dat (head),
      .level    (level)
   );

   // j,k double as the op register of the command in issue; rem_q counts the
   // cycles still to come after the current one, so len = max never overflows.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         j       <= 1'b0;
         k       <= 1'b0;
      end else if (pop) begin
         state_q <= ISSUE;
         rem_q   <= head[CNT_W-1:0];
         j       <= head[CNT_W+1];
         k       <= head[CNT_W];
      end else if ((state_q == ISSUE) && (rem_q != '0)) begin
         rem_q   <= rem_q - CNT_ONE;
      end else begin
         state_q <= IDLE;
         rem_q   <= '0;
         j       <= 1'b0;
         k       <= 1'b0;
      end
   end

   // Mirrors the downstream flip-flop, which samples the same registered j,k.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_exp <= 1'b0;
      end else begin
         case ({j, k})
            2'b01:   q_exp <= 1'b0;
            2'b10:   q_exp <= 1'b1;
            2'b11:   q_exp <= ~q_exp;
            default: q_exp <= q_exp;
         endcase
      end
   end

   assign busy       = (state_q == ISSUE);
   assign fifo_level = level;

endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed and random stimulus for jk_cmd_seq against a queue-based reference model.
// Each cycle the model predicts j, k, busy, q_exp, fifo_level and cmd_ready after the edge.
// Directed steps add explicit checks for set, toggle parity, chaining, full FIFO, mid-reset and max count.

module tb_jk_cmd_seq;

   localparam int DEPTH = 4;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;
   logic             j;
   logic             k;
   logic             busy;
   logic             q_exp;
   logic [2:0]       fifo_level;

   jk_cmd_seq #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_len    (cmd_len),
      .j          (j),
      .k          (k),
      .busy       (busy),
      .q_exp      (q_exp),
      .fifo_level (fifo_level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: pending commands in a queue, plus the op being driven
   // and how many drive cycles it still has (including the current one).
   typedef struct {
      logic [1:0] op;
      int         len;
   } cmd_t;

   cmd_t       mq[$];
   logic [1:0] m_op;
   int         m_left;
   logic       m_q;

   int n_chk;
   int n_pass;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge(input logic rst, input logic acc, input logic [1:0] op, input int len);
      cmd_t c;
      if (rst) begin
         mq.delete();
         m_op   = 2'b00;
         m_left = 0;
         m_q    = 1'b0;
      end else begin
         // Flip-flop reaction to what was being driven before this edge.
         if (m_op == 2'b01) m_q = 1'b0;
         else if (m_op == 2'b10) m_q = 1'b1;
         else if (m_op == 2'b11) m_q = ~m_q;
         if (m_left > 1) begin
            m_left = m_left - 1;
         end else if (mq.size() > 0) begin
            c      = mq.pop_front();
            m_op   = c.op;
            m_left = c.len + 1;
         end else begin
            m_op   = 2'b00;
            m_left = 0;
         end
         if (acc) begin
            c.op  = op;
            c.len = len;
            mq.push_back(c);
         end
      end
   endtask

   // One clock: apply inputs, advance the model at the edge, compare #1 later.
   task automatic cyc(input logic v, input logic [1:0] op, input logic [CNT_W-1:0] len, input logic rst);
      logic acc;
      reset     = rst;
      cmd_valid = v;
      cmd_op    = op;
      cmd_len   = len;
      acc = v && !rst && (mq.size() < DEPTH);
      @(posedge clk);
      model_edge(rst, acc, op, int'(len));
      #1;
      chk("j", {7'd0, j}, {7'd0, m_op[1]});
      chk("k", {7'd0, k}, {7'd0, m_op[0]});
      chk("busy", {7'd0, busy}, {7'd0, (m_left > 0)});
      chk("q_exp", {7'd0, q_exp}, {7'd0, m_q});
      chk("fifo_level", {5'd0, fifo_level}, 8'(mq.size()));
      chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, (mq.size() < DEPTH)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, '0, 1'b0);
   endtask

   initial begin
      logic       q0;
      logic [1:0] seq [6];
      int         cnt;
      int         idx;
      int         budget;
      logic       seen_full;

      n_chk  = 0;
      n_pass = 0;
      mq.delete();
      m_op   = 2'b00;
      m_left = 0;
      m_q    = 1'b0;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 2'b00;
      cmd_len   = '0;

      // Reset, with a command offered during reset that must be dropped.
      cyc(1'b0, 2'b00, '0, 1'b1);
      cyc(1'b1, 2'b10, 4'd3, 1'b1);
      idle(3);
      chk("rst_level", {5'd0, fifo_level}, 8'd0);

      // Single set command.
      cyc(1'b1, 2'b10, 4'd2, 1'b0);
      cnt = 0;
      for (int i = 0; i < 6; i++) begin
         cyc(1'b0, 2'b00, '0, 1'b0);
         if (j === 1'b1 && k === 1'b0) cnt++;
      end
      chk("set_cycles", 8'(cnt), 8'd3);
      chk("set_q", {7'd0, q_exp}, 8'd1);
      chk("set_busy", {7'd0, busy}, 8'd0);

      // Toggle parity: 5 toggles invert, 4 toggles leave q unchanged.
      q0 = m_q;
      cyc(1'b1, 2'b11, 4'd4, 1'b0);
      idle(8);
      chk("tog5_q", {7'd0, q_exp}, {7'd0, ~q0});
      q0 = m_q;
      cyc(1'b1, 2'b11, 4'd3, 1'b0);
      idle(8);
      chk("tog4_q", {7'd0, q_exp}, {7'd0, q0});

      // Back-to-back commands.
      cyc(1'b1, 2'b10, 4'd0, 1'b0);
      seq[0] = {j, k};
      cyc(1'b1, 2'b01, 4'd1, 1'b0);
      seq[1] = {j, k};
      cnt = busy ? 1 : 0;
      cyc(1'b1, 2'b11, 4'd0, 1'b0);
      seq[2] = {j, k};
      cnt += busy ? 1 : 0;
      for (int i = 3; i < 6; i++) begin
         cyc(1'b0, 2'b00, '0, 1'b0);
         seq[i] = {j, k};
         cnt += busy ? 1 : 0;
      end
      chk("b2b_jk1", {6'd0, seq[1]}, 8'h2);
      chk("b2b_jk2", {6'd0, seq[2]}, 8'h1);
      chk("b2b_jk3", {6'd0, seq[3]}, 8'h1);
      chk("b2b_jk4", {6'd0, seq[4]}, 8'h3);
      chk("b2b_jk5", {6'd0, seq[5]}, 8'h0);
      chk("b2b_busy", 8'(cnt), 8'd4);
      idle(2);

      // Full FIFO behind a long hold command; cmd_valid held throughout.
      idx = 0;
      budget = 0;
      seen_full = 1'b0;
      while (idx < 6 && budget < 60) begin
         logic acc;
         acc = (mq.size() < DEPTH);
         if (idx == 0) cyc(1'b1, 2'b00, 4'd15, 1'b0);
         else cyc(1'b1, 2'(idx), 4'(idx), 1'b0);
         if (acc) idx++;
         if (mq.size() == DEPTH && !seen_full) begin
            seen_full = 1'b1;
            chk("full_level", {5'd0, fifo_level}, 8'd4);
            chk("full_ready", {7'd0, cmd_ready}, 8'd0);
            chk("full_hold_busy", {7'd0, busy}, 8'd1);
         end
         budget++;
      end
      chk("full_done", 8'(idx), 8'd6);
      idle(40);

      // Reset in the middle of a long toggle with two commands queued.
      cyc(1'b1, 2'b11, 4'd10, 1'b0);
      idle(2);
      cyc(1'b1, 2'b10, 4'd3, 1'b0);
      cyc(1'b1, 2'b01, 4'd1, 1'b0);
      cyc(1'b0, 2'b00, '0, 1'b1);
      chk("mrst_jk", {6'd0, j, k}, 8'd0);
      chk("mrst_busy", {7'd0, busy}, 8'd0);
      chk("mrst_level", {5'd0, fifo_level}, 8'd0);
      chk("mrst_q", {7'd0, q_exp}, 8'd0);
      cnt = 0;
      for (int i = 0; i < 15; i++) begin
         cyc(1'b0, 2'b00, '0, 1'b0);
         if (busy !== 1'b0) cnt++;
      end
      chk("mrst_no_resume", 8'(cnt), 8'd0);

      // Maximum repeat count.
      cyc(1'b1, 2'b01, 4'd15, 1'b0);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         cyc(1'b0, 2'b00, '0, 1'b0);
         if (k === 1'b1) cnt++;
      end
      chk("max_cnt", 8'(cnt), 8'd16);

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         logic [CNT_W-1:0] rl;
         rl = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
         cyc(($urandom_range(0, 2) != 0), 2'($urandom_range(0, 3)), rl,
             ($urandom_range(0, 79) == 0));
      end
      idle(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
